crc32_checker: RTL and testbench

Receive-side CRC-32 frame checker, the counterpart of the byte-serial CRC-32 generator. It consumes a byte stream made of payload followed by a 4-byte CRC trailer, with `frame_end` on the last trailer byte. It holds the last four bytes in a delay buffer and runs the bitwise CRC over the payload only. It then compares the final CRC against the received trailer and reports pass/fail. It sits in the receive datapath between the byte source and the frame consumer.

---
 rtl/crc32_checker.sv | 172 +++++++++++++++++
 tb/tb_crc32_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_checker.sv
// Receive-side CRC-32 frame checker: delays the last 4 bytes as trailer, runs bitwise CRC on the payload.
// Optional bad-frame counter enabled by defining CRC32_CHK_ERRCNT_EN.
module crc32_checker #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             byte_valid,
   input  logic [7:0]       byte_in,
   input  logic             frame_end,
   output logic             byte_ready,
   input  logic             RefIn,
   input  logic             Init,
   input  logic             Xor_out,
   input  logic [31:0]      POLY_in,
   output logic             frame_done,
   output logic             crc_ok,
   output logic             len_err,
   output logic [31:0]      crc_calc,
   output logic [31:0]      crc_rx,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_SHIFT, S_CHECK} state_t;

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  buf_q [4];
   logic [7:0]  buf_d [4];
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic        last_q, last_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic        lerr_q, lerr_d;
   logic [31:0] calc_q, calc_d;
   logic [31:0] rx_q, rx_d;

   logic [31:0] poly_rev, poly, calc_fin, rx_asm, crc_step;
   logic        xfer;

   always_comb begin
      poly_rev = '0;
      for (int unsigned i = 0; i < 32; i++) poly_rev[i] = POLY_in[31-i];
   end

   assign poly     = RefIn ? poly_rev : POLY_in;
   assign xfer     = byte_valid & byte_ready;
   assign calc_fin = crc_q ^ {32{Xor_out}};
   // buf_q[0] is the oldest byte; unfilled slots stay zero for short frames
   assign rx_asm   = RefIn ? {buf_q[3], buf_q[2], buf_q[1], buf_q[0]}
                           : {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
   assign crc_step = RefIn ? (crc_q[0]  ? ((crc_q >> 1) ^ poly) : (crc_q >> 1))
                           : (crc_q[31] ? ((crc_q << 1) ^ poly) : (crc_q << 1));

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      buf_d      = buf_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      last_d     = last_q;
      done_d     = 1'b0;
      ok_d       = ok_q;
      lerr_d     = lerr_q;
      calc_d     = calc_q;
      rx_d       = rx_q;
      byte_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            byte_ready = 1'b1;
            crc_d      = {32{Init}};
            cnt_d      = 3'd0;
            bit_d      = 3'd0;
            last_d     = 1'b0;
            if (xfer) begin
               buf_d[0] = byte_in;
               buf_d[1] = '0;
               buf_d[2] = '0;
               buf_d[3] = '0;
               cnt_d    = 3'd1;
               state_d  = frame_end ? S_CHECK : S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            byte_ready = 1'b1;
            if (xfer) begin
               last_d = frame_end;
               if (cnt_q < 3'd4) begin
                  buf_d[cnt_q[1:0]] = byte_in;
                  cnt_d             = cnt_q + 3'd1;
                  if (frame_end) state_d = S_CHECK;
               end else begin
                  crc_d    = RefIn ? (crc_q ^ {24'h0, buf_q[0]}) : (crc_q ^ {buf_q[0], 24'h0});
                  buf_d[0] = buf_q[1];
                  buf_d[1] = buf_q[2];
                  buf_d[2] = buf_q[3];
                  buf_d[3] = byte_in;
                  state_d  = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            crc_d = crc_step;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = last_q ? S_CHECK : S_ACCEPT;
         end
         S_CHECK: begin
            calc_d  = calc_fin;
            rx_d    = rx_asm;
            lerr_d  = (cnt_q < 3'd4);
            ok_d    = !(cnt_q < 3'd4) && (calc_fin == rx_asm);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         crc_q   <= '0;
         buf_q   <= '{default: '0};
         cnt_q   <= '0;
         bit_q   <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         lerr_q  <= 1'b0;
         calc_q  <= '0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         last_q  <= last_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         lerr_q  <= lerr_d;
         calc_q  <= calc_d;
         rx_q    <= rx_d;
      end
   end

   assign frame_done = done_q;
   assign crc_ok     = ok_q;
   assign len_err    = lerr_q;
   assign crc_calc   = calc_q;
   assign crc_rx     = rx_q;

`ifdef CRC32_CHK_ERRCNT_EN
   logic [CNT_W-1:0] errc_q, errc_d;

   always_comb begin
      errc_d = errc_q;
      if (done_q && !ok_q && (errc_q != '1)) errc_d = errc_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) errc_q <= '0;
      else     errc_q <= errc_d;
   end

   assign err_count = errc_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_crc32_checker.sv
// Scoreboard bench for crc32_checker: driver queues expected results, monitor checks each frame_done.
module tb_crc32_checker;

`ifdef CRC32_CHK_ERRCNT_EN
   localparam bit ERRCNT_EN = 1'b1;
`else
   localparam bit ERRCNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        byte_valid, frame_end, byte_ready;
   logic [7:0]  byte_in;
   logic        RefIn, Init, Xor_out;
   logic [31:0] POLY_in;
   logic        frame_done, crc_ok, len_err;
   logic [31:0] crc_calc, crc_rx;
   logic [15:0] err_count;

   crc32_checker #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_in(byte_in),
      .frame_end(frame_end), .byte_ready(byte_ready), .RefIn(RefIn), .Init(Init),
      .Xor_out(Xor_out), .POLY_in(POLY_in), .frame_done(frame_done), .crc_ok(crc_ok),
      .len_err(len_err), .crc_calc(crc_calc), .crc_rx(crc_rx), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] calc;
      logic [31:0] rx;
      logic        ok;
      logic        len;
      int unsigned done_cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_chk = 0, n_pass = 0;
   int unsigned model_err = 0;
   int unsigned last_done = 0;
   int unsigned acc = 0;
   bit          chk_err = 1'b0;
   logic [7:0]  fr [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // monitor: every frame_done pops one expectation; err_count is checked one cycle later
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) chk_err = 1'b0;
         else begin
            if (chk_err) begin
               chk("err_count", 32'(err_count), ERRCNT_EN ? model_err : 0);
               chk_err = 1'b0;
            end
            if (frame_done) begin
               if (sb.size() == 0) chk("unexpected_frame_done", {31'b0, frame_done}, 32'd0);
               else begin
                  e = sb.pop_front();
                  chk("crc_calc", crc_calc, e.calc);
                  chk("crc_rx", crc_rx, e.rx);
                  chk("crc_ok", {31'b0, crc_ok}, {31'b0, e.ok});
                  chk("len_err", {31'b0, len_err}, {31'b0, e.len});
                  chk("done_latency", cyc, e.done_cyc);
                  if (!e.ok) model_err++;
                  chk_err   = 1'b1;
                  last_done = cyc;
               end
            end
         end
      end
   end

   // presents a junk byte while not ready so a wrongly accepted byte corrupts the frame
   task automatic send_byte(input logic [7:0] b, input logic fe);
      int unsigned n = 0;
      byte_valid = 1'b1;
      while (!byte_ready && n < 200) begin
         byte_in   = 8'hA5;
         frame_end = 1'b1;
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("ready_timeout", {31'b0, byte_ready}, 32'd1);
      byte_in   = b;
      frame_end = fe;
      @(posedge clk);
      @(negedge clk);
      acc        = cyc;
      byte_valid = 1'b0;
      frame_end  = 1'b0;
      byte_in    = 8'h00;
   endtask

   task automatic send_frame(input int unsigned n, input logic [31:0] calc, input logic [31:0] rx,
                             input logic ok, input logic len, input bit b2b);
      exp_t e;
      for (int unsigned i = 0; i < n; i++) begin
         send_byte(fr[i], (i == n - 1));
         if (b2b && i == 0) chk("b2b_start_cycle", acc, last_done + 1);
      end
      e.calc     = calc;
      e.rx       = rx;
      e.ok       = ok;
      e.len      = len;
      e.done_cyc = acc + ((n > 4) ? 9 : 1);
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic load_check(input logic [7:0] t0, input logic [7:0] t1,
                             input logic [7:0] t2, input logic [7:0] t3);
      for (int unsigned i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
      fr[9]  = t0;
      fr[10] = t1;
      fr[11] = t2;
      fr[12] = t3;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd1);
      chk({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
      chk({tag, "_crc_ok"}, {31'b0, crc_ok}, 32'd0);
      chk({tag, "_len_err"}, {31'b0, len_err}, 32'd0);
      chk({tag, "_crc_calc"}, crc_calc, 32'd0);
      chk({tag, "_crc_rx"}, crc_rx, 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin : driver
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      frame_end  = 1'b0;
      RefIn      = 1'b0;
      Init       = 1'b0;
      Xor_out    = 1'b0;
      POLY_in    = 32'h04C11DB7;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // CRC-32 (reflected)
      RefIn = 1'b1; Init = 1'b1; Xor_out = 1'b1;
      load_check(8'h26, 8'h39, 8'hF4, 8'hCB);
      send_frame(13, 32'hCBF43926, 32'hCBF43926, 1'b1, 1'b0, 1'b0);
      wait_drain();

      // CRC-32/BZIP2
      RefIn = 1'b0; Init = 1'b1; Xor_out = 1'b1;
      load_check(8'hFC, 8'h89, 8'h19, 8'h18);
      send_frame(13, 32'hFC891918, 32'hFC891918, 1'b1, 1'b0, 1'b0);
      wait_drain();

      // CRC-32/MPEG-2 with corrupted last trailer bit
      RefIn = 1'b0; Init = 1'b1; Xor_out = 1'b0;
      load_check(8'h03, 8'h76, 8'hE6, 8'hE6);
      send_frame(13, 32'h0376E6E7, 32'h0376E6E6, 1'b0, 1'b0, 1'b0);
      wait_drain();

      // 3-byte short frame, little-endian trailer with zero fill
      RefIn = 1'b1; Init = 1'b1; Xor_out = 1'b1;
      fr[0] = 8'hAA; fr[1] = 8'hBB; fr[2] = 8'hCC;
      send_frame(3, 32'h00000000, 32'h00CCBBAA, 1'b0, 1'b1, 1'b0);
      wait_drain();

      // 1-byte frame straight from IDLE, big-endian trailer with zero fill
      RefIn = 1'b0; Init = 1'b0; Xor_out = 1'b0;
      fr[0] = 8'h5A;
      send_frame(1, 32'h00000000, 32'h5A000000, 1'b0, 1'b1, 1'b0);
      wait_drain();

      // exactly 4 bytes: empty payload, crc_calc is the Init value
      RefIn = 1'b0; Init = 1'b1; Xor_out = 1'b0;
      for (int unsigned i = 0; i < 4; i++) fr[i] = 8'hFF;
      send_frame(4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
      wait_drain();

      // reset during SHIFT: frame discarded, outputs cleared, no frame_done
      RefIn = 1'b1; Init = 1'b1; Xor_out = 1'b1;
      load_check(8'h26, 8'h39, 8'hF4, 8'hCB);
      for (int unsigned i = 0; i < 5; i++) send_byte(fr[i], 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle_outputs("midreset");
      model_err = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // back-to-back frames: second starts on the first frame's frame_done cycle
      for (int unsigned i = 0; i < 4; i++) fr[i] = 8'h00;
      send_frame(4, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
      load_check(8'h26, 8'h39, 8'hF4, 8'hCB);
      send_frame(13, 32'hCBF43926, 32'hCBF43926, 1'b1, 1'b0, 1'b1);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
